// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared state encoding and array instruction constants for the MAC tile sequencer
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/ctrl_counter.sv
// rtl/ctrl_counter.sv - loadable up-counter with terminal-compare output
module ctrl_counter #(
  parameter int width = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] load_val,
  input  logic             en,
  input  logic [width-1:0] terminal,
  output logic [width-1:0] count,
  output logic             at_term
);

  // Load has priority over counting so a phase change restarts cleanly in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + width'(1);
    end
  end

  assign at_term = (count == terminal);

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - MAC array tile sequencer (kernel load, settle, execute, drain); optional MAC_SEQ_CTRL_PERF_EN adds perf_cycles
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int cnt_w  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_sel_in,
  input  logic [addr_w-1:0] w_base,
  input  logic [addr_w-1:0] a_base,
  input  logic [cnt_w-1:0]  num_act,
  input  logic [col-1:0]    valid,
  output logic              w_rd_en,
  output logic [addr_w-1:0] w_addr,
  output logic              a_rd_en,
  output logic [addr_w-1:0] a_addr,
  output logic [1:0]        inst_w,
  output logic              mode_sel,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef MAC_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam logic [cnt_w-1:0] row_last   = cnt_w'(row - 1);
  localparam logic [cnt_w-1:0] col_last   = cnt_w'(col - 1);
  localparam logic [cnt_w-1:0] drain_last = cnt_w'(row + col + 3);

  state_t state_q, state_d;

  logic [addr_w-1:0] w_base_q;
  logic [addr_w-1:0] a_base_q;
  logic [cnt_w-1:0]  num_act_q;

  logic              accept;
  logic              phase_load;
  logic [cnt_w-1:0]  phase_term;
  logic [cnt_w-1:0]  phase_cnt;
  logic              phase_tc;
  logic [addr_w-1:0] offset;
  logic              offset_tc_unused;
  logic [cnt_w-1:0]  vcnt;
  logic              vcnt_tc;
  logic              counted_valid;
  logic              drain_complete;
  logic [cnt_w-1:0]  timer;
  logic              timer_tc;

  // Only the last column's valid marks a fully drained psum row; other lanes are not consulted.
  logic [col-1:0]    valid_lanes_unused;
  assign valid_lanes_unused = valid;

  assign accept = (state_q == ST_IDLE) && start && (num_act != '0);

  // Phase length depends on which timed phase is active.
  assign phase_term = (state_q == ST_LOAD)   ? row_last :
                      (state_q == ST_SETTLE) ? col_last :
                      (state_q == ST_EXEC)   ? (num_act_q - cnt_w'(1)) : '0;

  // Phase and address-offset counters restart on every state change.
  assign phase_load = (state_d != state_q) || (state_q == ST_IDLE);

  // A valid is counted only once reads to the array have begun and the quota is not yet met.
  assign counted_valid  = valid[col-1] &&
                          ((state_q == ST_EXEC) || (state_q == ST_DRAIN)) &&
                          (vcnt != num_act_q);
  assign drain_complete = (vcnt == num_act_q) || (counted_valid && vcnt_tc);

  ctrl_counter #(.width(cnt_w)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (phase_load),
    .load_val ('0),
    .en       (1'b1),
    .terminal (phase_term),
    .count    (phase_cnt),
    .at_term  (phase_tc)
  );

  ctrl_counter #(.width(addr_w)) u_offset_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (phase_load),
    .load_val ('0),
    .en       (w_rd_en || a_rd_en),
    .terminal ('0),
    .count    (offset),
    .at_term  (offset_tc_unused)
  );

  ctrl_counter #(.width(cnt_w)) u_valid_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == ST_IDLE),
    .load_val ('0),
    .en       (counted_valid),
    .terminal (num_act_q - cnt_w'(1)),
    .count    (vcnt),
    .at_term  (vcnt_tc)
  );

  // Drain timer runs only in DRAIN and restarts on each counted valid.
  ctrl_counter #(.width(cnt_w)) u_drain_timer (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_q != ST_DRAIN) || counted_valid),
    .load_val ('0),
    .en       (state_q == ST_DRAIN),
    .terminal (drain_last),
    .count    (timer),
    .at_term  (timer_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operation parameters are captured only on an accepted start so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_base_q  <= '0;
      a_base_q  <= '0;
      num_act_q <= '0;
      mode_sel  <= 1'b0;
    end else if (accept) begin
      w_base_q  <= w_base;
      a_base_q  <= a_base;
      num_act_q <= num_act;
      mode_sel  <= mode_sel_in;
    end
  end

  // Instruction trails the read enable by one cycle to line up with SRAM read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_w <= INST_IDLE;
    end else if (w_rd_en) begin
      inst_w <= INST_LOAD;
    end else if (a_rd_en) begin
      inst_w <= INST_EXEC;
    end else begin
      inst_w <= INST_IDLE;
    end
  end

  // Next-state and read/status outputs; addresses are held at zero outside their read phase.
  always_comb begin
    state_d = state_q;
    w_rd_en = 1'b0;
    a_rd_en = 1'b0;
    w_addr  = '0;
    a_addr  = '0;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        w_rd_en = 1'b1;
        w_addr  = w_base_q + offset;
        if (phase_tc) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (phase_tc) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        a_rd_en = 1'b1;
        a_addr  = a_base_q + offset;
        if (phase_tc) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_complete) begin
          state_d = ST_DONE;
        end else if (timer_tc) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef MAC_SEQ_CTRL_PERF_EN
  // Busy-cycle count of the current operation; holds after completion until the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
    end else if (state_q != ST_IDLE) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - directed self-checking bench for mac_seq_ctrl
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode_sel_in = 1'b0;
  logic [10:0] w_base = '0;
  logic [10:0] a_base = '0;
  logic [10:0] num_act = '0;
  logic [7:0]  valid = '0;
  logic        w_rd_en;
  logic [10:0] w_addr;
  logic        a_rd_en;
  logic [10:0] a_addr;
  logic [1:0]  inst_w;
  logic        mode_sel;
  logic        busy;
  logic        done;
  logic        err;
`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  mac_seq_ctrl #(.row(8), .col(8), .addr_w(11), .cnt_w(11)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode_sel_in (mode_sel_in),
    .w_base      (w_base),
    .a_base      (a_base),
    .num_act     (num_act),
    .valid       (valid),
    .w_rd_en     (w_rd_en),
    .w_addr      (w_addr),
    .a_rd_en     (a_rd_en),
    .a_addr      (a_addr),
    .inst_w      (inst_w),
    .mode_sel    (mode_sel),
    .busy        (busy),
    .done        (done),
    .err         (err)
`ifdef MAC_SEQ_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] obs();
    return {w_rd_en, w_addr, a_rd_en, a_addr, inst_w, busy, done, err, mode_sel};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_op(input logic [10:0] wb, input logic [10:0] ab,
                          input logic [10:0] n, input logic m);
    w_base = wb;
    a_base = ab;
    num_act = n;
    mode_sel_in = m;
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    w_base = 11'h555;
    a_base = 11'h2AA;
    num_act = 11'd7;
    mode_sel_in = ~m;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if (obs() !== 31'h0) begin
      fails++;
      $display("FAIL reset_held got %h want %h", obs(), 31'h0);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (obs() !== 31'h0) begin
      fails++;
      $display("FAIL reset_released got %h want %h", obs(), 31'h0);
    end
  endtask

  task automatic test_nominal();
    logic [30:0] e;
    logic        e_wrd, e_ard, e_busy, e_done;
    logic [10:0] e_wa, e_aa;
    logic [1:0]  e_inst;
    start_op(11'h010, 11'h040, 11'd4, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      valid = 8'h00;
      if (c == 3 || c == 12 || c == 23 || c == 24 || c == 26 || c == 28) valid[7] = 1'b1;
      if (c == 22 || c == 25) valid[0] = 1'b1;
      e_wrd  = (c >= 1 && c <= 8);
      e_wa   = e_wrd ? 11'h010 + 11'(c - 1) : 11'h000;
      e_ard  = (c >= 17 && c <= 20);
      e_aa   = e_ard ? 11'h040 + 11'(c - 17) : 11'h000;
      e_inst = (c >= 2 && c <= 9) ? 2'b01 : (c >= 18 && c <= 21) ? 2'b10 : 2'b00;
      e_busy = (c <= 29);
      e_done = (c == 29);
      e = {e_wrd, e_wa, e_ard, e_aa, e_inst, e_busy, e_done, 1'b0, 1'b1};
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL nominal cycle %0d got %h want %h", c, obs(), e);
      end
      tick();
    end
    valid = 8'h00;
  endtask

  task automatic test_zero_count();
    start_op(11'h010, 11'h040, 11'd0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      tests++;
      if (obs() !== 31'h1) begin
        fails++;
        $display("FAIL zero_count cycle %0d got %h want %h", c, obs(), 31'h1);
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    logic [2:0] e;
    start_op(11'h000, 11'h100, 11'd2, 1'b0);
    for (int c = 1; c <= 35; c++) begin
      valid = (c == 20 || c == 21) ? 8'h80 : 8'h00;
      start = (c == 17);
      mode_sel_in = 1'b1;
      num_act = 11'd5;
      e = {(c <= 22), (c == 22), 1'b0};
      tests++;
      if ({busy, done, mode_sel} !== e) begin
        fails++;
        $display("FAIL start_busy cycle %0d got %b want %b", c, {busy, done, mode_sel}, e);
      end
      tick();
    end
    start = 1'b0;
    valid = 8'h00;
  endtask

  task automatic test_addr_wrap();
    logic [10:0] wrap_exp [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    logic [14:0] e;
    logic        e_ard;
    logic [10:0] e_aa;
    start_op(11'h000, 11'h7FE, 11'd4, 1'b0);
    for (int c = 1; c <= 28; c++) begin
      valid = (c >= 21 && c <= 24) ? 8'h80 : 8'h00;
      e_ard = (c >= 17 && c <= 20);
      e_aa  = e_ard ? wrap_exp[c - 17] : 11'h000;
      e = {e_ard, e_aa, ((c >= 18 && c <= 21) ? 2'b10 : ((c >= 2 && c <= 9) ? 2'b01 : 2'b00)), (c == 25)};
      tests++;
      if ({a_rd_en, a_addr, inst_w, done} !== e) begin
        fails++;
        $display("FAIL addr_wrap cycle %0d got %h want %h", c, {a_rd_en, a_addr, inst_w, done}, e);
      end
      tick();
    end
    valid = 8'h00;
  endtask

  task automatic test_drain_timeout();
    logic [2:0] e;
    start_op(11'h020, 11'h060, 11'd3, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      valid = 8'h00;
      e = {(c <= 40), 1'b0, (c == 40)};
      tests++;
      if ({busy, done, err} !== e) begin
        fails++;
        $display("FAIL timeout cycle %0d got %b want %b", c, {busy, done, err}, e);
      end
      tick();
    end
    start_op(11'h020, 11'h060, 11'd3, 1'b0);
    for (int c = 1; c <= 48; c++) begin
      valid = (c == 22) ? 8'h80 : 8'h00;
      e = {(c <= 43), 1'b0, (c == 43)};
      tests++;
      if ({busy, done, err} !== e) begin
        fails++;
        $display("FAIL timeout_cleared cycle %0d got %b want %b", c, {busy, done, err}, e);
      end
      tick();
    end
    valid = 8'h00;
  endtask

  task automatic test_reset_mid_load();
    logic [13:0] e;
    start_op(11'h010, 11'h040, 11'd4, 1'b1);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (obs() !== 31'h0) begin
      fails++;
      $display("FAIL reset_mid_load got %h want %h", obs(), 31'h0);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      tests++;
      if (obs() !== 31'h0) begin
        fails++;
        $display("FAIL reset_quiet cycle %0d got %h want %h", c, obs(), 31'h0);
      end
    end
    start_op(11'h010, 11'h040, 11'd4, 1'b0);
    for (int c = 1; c <= 31; c++) begin
      valid = (c == 23 || c == 24 || c == 26 || c == 28) ? 8'h80 : 8'h00;
      e = {(c <= 8), ((c <= 8) ? 11'h010 + 11'(c - 1) : 11'h000), (c <= 29), (c == 29)};
      tests++;
      if ({w_rd_en, w_addr, busy, done} !== e) begin
        fails++;
        $display("FAIL rerun cycle %0d got %h want %h", c, {w_rd_en, w_addr, busy, done}, e);
      end
      tick();
    end
    valid = 8'h00;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_count();
    test_start_while_busy();
    test_addr_wrap();
    test_drain_timeout();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the 2D MAC array tile. On a start pulse it:
- issues kernel-SRAM reads and drives the array's kernel-load instruction;
- waits for the weights to settle across the columns;
- streams activation-SRAM reads under the execute instruction;
- counts south-edge `valid` pulses until every psum row has drained, then pulses `done`.

It sits between the top-level core FSM and the MAC array / SRAM pair and owns `inst_w` and `mode_sel` for the array.

## Interface
Parameters:
- `row`, 8, array rows (kernel vectors per load)
- `col`, 8, array columns
- `addr_w`, 11, SRAM address width
- `cnt_w`, 11, width of activation count

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `mode_sel_in`  in  1  array mode; latched on accepted start
- `w_base`  in  addr_w  first kernel SRAM address; latched on start
- `a_base`  in  addr_w  first activation SRAM address; latched on start
- `num_act`  in  cnt_w  activation vectors to execute; latched on start
- `valid`  in  col  south-edge valid from the array
- `w_rd_en`  out  1  kernel SRAM read enable
- `w_addr`  out  addr_w  kernel SRAM address
- `a_rd_en`  out  1  activation SRAM read enable
- `a_addr`  out  addr_w  activation SRAM address
- `inst_w`  out  2  array instruction: [1] execute, [0] kernel load
- `mode_sel`  out  1  latched mode to array
- `busy`  out  1  high in any state but IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle drain-timeout pulse

## Operation
- **IDLE**
  - `start` with `num_act`≠0 → LOAD.
  - `start` with `num_act`=0 is ignored: no state change, no `done`.
- **LOAD**, `row` cycles.
  - `w_rd_en`=1; `w_addr` = `w_base`+k for k = 0..row-1.
  - Then → SETTLE.
- **SETTLE**, `col` cycles.
  - No reads; instruction 00.
  - Then → EXEC.
- **EXEC**, `num_act` cycles.
  - `a_rd_en`=1; `a_addr` = `a_base`+j for j = 0..num_act-1.
  - Then → DRAIN.
- **DRAIN**
  - Count cycles with `valid[col-1]`=1.
  - Count == `num_act` → DONE.
  - Drain timer reaches `row`+`col`+4 without completing → ERR.
- **DONE** / **ERR**
  - One cycle each; pulse `done` / `err` respectively.
  - Then → IDLE.
- Address arithmetic is modulo 2^addr_w; wrap past the top is silent.
- `valid` pulses in IDLE, LOAD or SETTLE are ignored and not counted. Pulses beyond `num_act` cannot occur because the state exits on equality.
- `start` while `busy` is ignored.
- `mode_sel` holds its latched value until the next accepted start.

## Timing
- SRAM read latency is 1 cycle. `inst_w` is registered one cycle after the read phase so the instruction aligns with the SRAM data arriving at `in_w`:
  - `inst_w`=01 in the cycle after each `w_rd_en`;
  - `inst_w`=10 in the cycle after each `a_rd_en`;
  - 00 otherwise.
- Start accepted at cycle 0 → first `w_rd_en` at cycle 1.
- Drain timer starts at DRAIN entry; it is cleared by each counted `valid[col-1]`.
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-operation returns to IDLE on the next edge and forces `inst_w`=00. No `done` or `err` is emitted.

## Configuration
- `MAC_SEQ_CTRL_PERF_EN`
  - **Defined:** adds output `perf_cycles` [31:0], which counts `busy` cycles of the current operation. It is cleared on accepted start and holds its value after DONE/ERR until the next start; reset value is 0.
  - **Undefined:** the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package `mac_ctrl_pkg`:
  - state encoding (IDLE, LOAD, SETTLE, EXEC, DRAIN, DONE, ERR);
  - instruction constants `INST_IDLE`=2'b00, `INST_LOAD`=2'b01, `INST_EXEC`=2'b10.
- One sub-module, `ctrl_counter`: a loadable up-counter with terminal-compare output. It is instantiated for the phase count, the address offset, the valid count and the drain timer.

## Test plan
Defaults: `row`=8, `col`=8 unless stated.
- **Nominal run.** `num_act`=4, `w_base`=0x10, `a_base`=0x40, array model returns 4 `valid[7]` pulses.
  - `w_addr` 0x10..0x17 on cycles 1–8; `inst_w`=01 on cycles 2–9.
  - `a_addr` 0x40..0x43 on cycles 17–20; `inst_w`=10 on cycles 18–21.
  - `done` is pulsed one cycle after the 4th pulse.
- **Zero count.** `num_act`=0 with `start` → `busy` stays 0; no reads, no `done`.
- **Start while busy.** Second `start` (`mode_sel_in`=1) during EXEC of a `mode_sel_in`=0 run → ignored; `mode_sel` stays 0; single `done`.
- **Address wrap.** `a_base`=0x7FE, `num_act`=4 → `a_addr` sequence 0x7FE, 0x7FF, 0x000, 0x001.
- **Drain timeout.** Model withholds `valid` → `err` pulses exactly 20 cycles after DRAIN entry; no `done`; returns to IDLE.
- **Reset mid-LOAD.** Reset at cycle 4 → next cycle all outputs 0 and IDLE; a following `start` runs the nominal sequence cleanly.
